// File: rtl/muldiv4_pkg.sv
// Shared definitions for the muldiv4 datapath: command encodings, the
// sequencing FSM states and the accumulator saturation limits.
package muldiv4_pkg;

   localparam int MUL_W = 8;

   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,
      OP_MAC  = 2'b01,
      OP_CLR  = 2'b10,
      OP_READ = 2'b11
   } macOp_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_DONE
   } macState_e;

   // Clamp value for a width-bit accumulator; 'negative' selects the
   // lower bound and only matters in two's complement mode.
   function automatic logic [63:0] satLimit(input int width, input logic isSigned,
                                            input logic negative);
      logic [63:0] lim;
      if (!isSigned)
         lim = (64'd1 << width) - 64'd1;
      else if (negative)
         lim = ~((64'd1 << (width - 1)) - 64'd1);
      else
         lim = (64'd1 << (width - 1)) - 64'd1;
      return lim;
   endfunction

endpackage

// File: rtl/mul4.sv
// 4x4 array multiplier, signed or unsigned; the 8-bit product is exact in
// both modes because the operands are extended before summing the rows.
module mul4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       opsigned,
   output logic [7:0] p
);

   logic [7:0] aExt;
   logic [7:0] bExt;
   logic [7:0] rowSum;

   assign aExt = opsigned ? {{4{a[3]}}, a} : {4'b0000, a};
   assign bExt = opsigned ? {{4{b[3]}}, b} : {4'b0000, b};

   always_comb begin
      // NOTE: every variable written here gets a value before any branch,
      // otherwise synthesis infers a latch to hold the old value.
      rowSum = 8'd0;
      for (int i = 0; i < 8; i++) begin
         if (bExt[i])
            rowSum = rowSum + (aExt << i);
      end
   end

   assign p = rowSum;

endmodule

// File: rtl/mul4_mac_ctrl.sv
// Front/back sequencing stage around mul4: takes one command, multiplies,
// optionally accumulates with saturation, and holds the result until taken.
module mul4_mac_ctrl
   import muldiv4_pkg::*;
#(
   parameter int ACC_W   = 10,
   parameter bit SAT_ACC = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [3:0]       in_a,
   input  logic [3:0]       in_b,
   input  logic             in_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_res,
   output logic             out_ovf,
   output logic             out_zero
);

   macState_e        state;
   macState_e        nextState;
   macOp_e           opReg;
   logic [3:0]       aReg;
   logic [3:0]       bReg;
   logic             sgnReg;
   logic [MUL_W-1:0] prod;

   logic [ACC_W-1:0] acc;
   logic             ovf;
   logic [ACC_W-1:0] resReg;

   logic [ACC_W-1:0] pe;
   logic [ACC_W:0]   sum;
   logic             macOvf;
   logic [ACC_W-1:0] macVal;
   logic [ACC_W-1:0] accNext;
   logic [ACC_W-1:0] resNext;
   logic             ovfNext;

   mul4 uMul (
      .a        (aReg),
      .b        (bReg),
      .opsigned (sgnReg),
      .p        (prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      if (!rst_n) state <= ST_IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE: if (in_valid)  nextState = ST_EXEC;
         ST_EXEC:                nextState = ST_DONE;
         ST_DONE: if (out_ready) nextState = ST_IDLE;
         default:                nextState = ST_IDLE;
      endcase
   end

   // Product extension and the one-bit-wider sum that exposes the carry.
   assign pe  = sgnReg ? {{(ACC_W-MUL_W){prod[MUL_W-1]}}, prod}
                       : {{(ACC_W-MUL_W){1'b0}}, prod};
   assign sum = {1'b0, acc} + {1'b0, pe};

   assign macOvf = sgnReg ? ((acc[ACC_W-1] == pe[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]))
                          : sum[ACC_W];
   assign macVal = (macOvf && SAT_ACC) ? ACC_W'(satLimit(ACC_W, sgnReg, acc[ACC_W-1]))
                                       : sum[ACC_W-1:0];

   always_comb begin
      resNext = resReg;
      accNext = acc;
      ovfNext = ovf;
      case (opReg)
         OP_MUL:  resNext = pe;
         OP_MAC: begin
            accNext = macVal;
            resNext = macVal;
            ovfNext = ovf | macOvf;
         end
         OP_CLR: begin
            accNext = '0;
            resNext = '0;
            ovfNext = 1'b0;
         end
         OP_READ: resNext = acc;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: operand registers are reset too so the multiplier never sees X
      // and the held result after reset is a defined zero.
      if (!rst_n) begin
         opReg  <= OP_MUL;
         aReg   <= '0;
         bReg   <= '0;
         sgnReg <= 1'b0;
         acc    <= '0;
         ovf    <= 1'b0;
         resReg <= '0;
      end else begin
         if (state == ST_IDLE && in_valid) begin
            opReg  <= macOp_e'(in_op);
            aReg   <= in_a;
            bReg   <= in_b;
            sgnReg <= in_signed;
         end
         if (state == ST_EXEC) begin
            acc    <= accNext;
            ovf    <= ovfNext;
            resReg <= resNext;
         end
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign out_res   = resReg;
   assign out_zero  = (resReg == '0);
   assign out_ovf   = ovf;

endmodule

// File: tb/tb_mul4_mac_ctrl.sv
// Bench for mul4_mac_ctrl: a saturating and a wrapping instance share one
// stimulus stream and are compared against an integer-arithmetic model.
module tb_mul4_mac_ctrl;

   localparam int W = 10;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic [1:0]       in_op;
   logic [3:0]       in_a;
   logic [3:0]       in_b;
   logic             in_signed;
   logic             out_ready;

   logic [1:0]        inRdy;
   logic [1:0]        outVal;
   logic [1:0]        outOvf;
   logic [1:0]        outZero;
   logic [1:0][W-1:0] outRes;

   int checks = 0;
   int errors = 0;

   // Model state: index 0 is the saturating instance, index 1 wraps.
   int mAcc[2];
   bit mOvf[2];
   int mRes[2];

   mul4_mac_ctrl #(.ACC_W(W), .SAT_ACC(1'b1)) dutSat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inRdy[0]),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
      .out_valid(outVal[0]), .out_ready(out_ready), .out_res(outRes[0]),
      .out_ovf(outOvf[0]), .out_zero(outZero[0])
   );

   mul4_mac_ctrl #(.ACC_W(W), .SAT_ACC(1'b0)) dutWrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inRdy[1]),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
      .out_valid(outVal[1]), .out_ready(out_ready), .out_res(outRes[1]),
      .out_ovf(outOvf[1]), .out_zero(outZero[1])
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void modelReset();
      for (int k = 0; k < 2; k++) begin
         mAcc[k] = 0;
         mOvf[k] = 1'b0;
         mRes[k] = 0;
      end
   endfunction

   function automatic void modelCmd(input logic [1:0] op, input logic [3:0] a,
                                    input logic [3:0] b, input logic sgn);
      int sa, sb, p, s, av;
      sa = (sgn && a >= 8) ? int'(a) - 16 : int'(a);
      sb = (sgn && b >= 8) ? int'(b) - 16 : int'(b);
      p  = sa * sb;
      for (int k = 0; k < 2; k++) begin
         case (op)
            2'b00: mRes[k] = p & 1023;
            2'b01: begin
               if (sgn) begin
                  av = (mAcc[k] >= 512) ? mAcc[k] - 1024 : mAcc[k];
                  s  = av + p;
                  if (s > 511 || s < -512) begin
                     mOvf[k] = 1'b1;
                     if (k == 0) s = (s > 511) ? 511 : -512;
                  end
               end else begin
                  s = mAcc[k] + p;
                  if (s > 1023) begin
                     mOvf[k] = 1'b1;
                     if (k == 0) s = 1023;
                  end
               end
               mAcc[k] = s & 1023;
               mRes[k] = mAcc[k];
            end
            2'b10: begin
               mAcc[k] = 0;
               mOvf[k] = 1'b0;
               mRes[k] = 0;
            end
            default: mRes[k] = mAcc[k];
         endcase
      end
   endfunction

   task automatic checkOut(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_valid%0d", tag, k), 16'(outVal[k]), 16'd1);
         check($sformatf("%s_res%0d", tag, k), 16'(outRes[k]), 16'(mRes[k]));
         check($sformatf("%s_ovf%0d", tag, k), 16'(outOvf[k]), 16'(mOvf[k]));
         check($sformatf("%s_zero%0d", tag, k), 16'(outZero[k]), 16'(mRes[k] == 0));
      end
   endtask

   // One full command: accept, execute, present, optional stall, handshake.
   // expRes values < 0 mean no extra test-plan constant for that instance.
   task automatic runCmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic sgn, input int stall, input int expRes0, input int expRes1);
      @(negedge clk);
      in_valid  = 1'b1;
      in_op     = op;
      in_a      = a;
      in_b      = b;
      in_signed = sgn;
      out_ready = 1'b0;
      check("accept_ready", 16'(inRdy), 16'h3);
      @(posedge clk);
      modelCmd(op, a, b, sgn);
      @(negedge clk);
      in_valid = 1'b0;
      check("exec_valid", 16'(outVal), 16'h0);
      check("exec_ready", 16'(inRdy), 16'h0);
      @(negedge clk);
      checkOut("done");
      if (expRes0 >= 0) check("plan_res_sat", 16'(outRes[0]), expRes0[15:0]);
      if (expRes1 >= 0) check("plan_res_wrap", 16'(outRes[1]), expRes1[15:0]);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         checkOut("stall");
         check("stall_ready", 16'(inRdy), 16'h0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("ack_valid", 16'(outVal), 16'h0);
      check("ack_ready", 16'(inRdy), 16'h3);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_op     = 2'b01;
      in_a      = 4'h7;
      in_b      = 4'h7;
      in_signed = 1'b1;
      out_ready = 1'b0;
      modelReset();
      #1;
      check("rst_valid", 16'(outVal), 16'h0);
      check("rst_res", 16'(outRes), 16'h0);
      check("rst_zero", 16'(outZero), 16'h3);
      check("rst_ovf", 16'(outOvf), 16'h0);
      check("rst_ready", 16'(inRdy), 16'h3);
      repeat (2) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      check("post_rst_valid", 16'(outVal), 16'h0);
      check("post_rst_ready", 16'(inRdy), 16'h3);

      // Multiplier corners and accumulator untouched by MUL.
      runCmd(2'b00, 4'hF, 4'hF, 1'b0, 0, 225, 225);
      runCmd(2'b11, 4'h0, 4'h0, 1'b0, 0, 0, 0);
      runCmd(2'b00, 4'h8, 4'h8, 1'b1, 0, 64, 64);
      runCmd(2'b00, 4'h8, 4'h7, 1'b1, 0, 'h3C8, 'h3C8);
      runCmd(2'b00, 4'h8, 4'h8, 1'b0, 0, 64, 64);

      // Signed MAC into positive saturation.
      runCmd(2'b10, 4'h0, 4'h0, 1'b0, 0, 0, 0);
      for (int i = 1; i <= 10; i++) runCmd(2'b01, 4'h7, 4'h7, 1'b1, 0, 49 * i, 49 * i);
      runCmd(2'b01, 4'h7, 4'h7, 1'b1, 0, 511, 539);
      runCmd(2'b11, 4'h0, 4'h0, 1'b1, 0, 511, 539);
      runCmd(2'b10, 4'h0, 4'h0, 1'b1, 0, 0, 0);

      // Unsigned MAC past the carry-out.
      for (int i = 1; i <= 4; i++) runCmd(2'b01, 4'hF, 4'hF, 1'b0, 0, 225 * i, 225 * i);
      runCmd(2'b01, 4'hF, 4'hF, 1'b0, 0, 1023, 101);

      // Backpressure with a second command held throughout.
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'b00; in_a = 4'h3; in_b = 4'h5; in_signed = 1'b0;
      @(posedge clk);
      modelCmd(2'b00, 4'h3, 4'h5, 1'b0);
      @(negedge clk);
      in_op = 2'b11; in_a = 4'hA; in_b = 4'h6; in_signed = 1'b0;
      check("bp_exec_valid", 16'(outVal), 16'h0);
      @(negedge clk);
      checkOut("bp_first");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOut("bp_hold");
         check("bp_hold_ready", 16'(inRdy), 16'h0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_ack_valid", 16'(outVal), 16'h0);
      check("bp_ack_ready", 16'(inRdy), 16'h3);
      @(posedge clk);
      modelCmd(2'b11, 4'hA, 4'h6, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_second_exec", 16'(outVal), 16'h0);
      check("bp_second_ready", 16'(inRdy), 16'h0);
      @(negedge clk);
      checkOut("bp_second");
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Asynchronous reset while a MAC is executing.
      runCmd(2'b10, 4'h0, 4'h0, 1'b1, 0, 0, 0);
      runCmd(2'b01, 4'h7, 4'h7, 1'b1, 0, 49, 49);
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'b01; in_a = 4'h7; in_b = 4'h7; in_signed = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      modelReset();
      #1;
      check("midrst_valid", 16'(outVal), 16'h0);
      check("midrst_ready", 16'(inRdy), 16'h3);
      check("midrst_res", 16'(outRes), 16'h0);
      check("midrst_zero", 16'(outZero), 16'h3);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_after_valid", 16'(outVal), 16'h0);
      runCmd(2'b11, 4'h0, 4'h0, 1'b1, 0, 0, 0);

      // Randomized commands against the model.
      for (int i = 0; i < 60; i++) begin
         runCmd(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 1'($urandom),
                $urandom_range(0, 2), -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
